// File: rtl/wb_native_bridge_pkg.sv
// wb_native_bridge_pkg: FSM encoding, native-bus constants and address helper
package wb_native_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_ACK
    } state_t;

    localparam logic [3:0] WSTRB_READ = 4'b0000;

    function automatic logic [31:0] native_addr(
        input logic [31:0] mem_base,
        input logic [31:0] wb_mask,
        input logic [31:0] wb_adr
    );
        return (mem_base | (wb_adr & ~wb_mask)) & ~32'h3;
    endfunction

endpackage

// File: rtl/wb_native_bridge_if.sv
// wb_native_bridge_if: Wishbone-classic slave side plus picosoc native initiator side
interface wb_native_bridge_if;

    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        mem_valid;
    logic        mem_instr;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o,
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o,
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );

endinterface

// File: rtl/wb_native_bridge.sv
// wb_native_bridge: Wishbone-classic slave issuing single word transfers on the picosoc native bus
module wb_native_bridge
    import wb_native_bridge_pkg::*;
#(
    parameter logic [31:0] WB_BASE  = 32'h3000_0000,
    parameter logic [31:0] WB_MASK  = 32'hFFFF_0000,
    parameter logic [31:0] MEM_BASE = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic              clk,
    input  logic              resetn,
    wb_native_bridge_if.slave bus,
    output logic              timeout_o
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] rdata_q, rdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        abort_q, abort_d;
    logic        timeout_q, timeout_d;
    logic        req_w;

    assign req_w = bus.wbs_cyc_i && bus.wbs_stb_i && ((bus.wbs_adr_i & WB_MASK) == WB_BASE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= WSTRB_READ;
            rdata_q   <= '0;
            cnt_q     <= '0;
            abort_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
            abort_q   <= abort_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        abort_d   = abort_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                rdata_d = '0;
                cnt_d   = '0;
                if (req_w) begin
                    addr_d  = native_addr(MEM_BASE, WB_MASK, bus.wbs_adr_i);
                    wdata_d = bus.wbs_dat_i;
                    wstrb_d = bus.wbs_we_i ? bus.wbs_sel_i : WSTRB_READ;
                    abort_d = 1'b0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // A dropped cyc only suppresses the ack; the native request still runs to completion.
                abort_d = abort_q || !bus.wbs_cyc_i;
                if (bus.mem_ready) begin
                    rdata_d = (wstrb_q == WSTRB_READ) ? bus.mem_rdata : '0;
                    state_d = ST_ACK;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d   = ERR_DATA;
                    timeout_d = 1'b1;
                    state_d   = ST_ACK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ACK: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.mem_valid = (state_q == ST_REQ);
    assign bus.mem_instr = 1'b0;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_wstrb = wstrb_q;
    assign bus.wbs_ack_o = (state_q == ST_ACK) && !abort_q;
    assign bus.wbs_dat_o = bus.wbs_ack_o ? rdata_q : '0;
    assign timeout_o     = timeout_q;

endmodule
